// File: rtl/sp_ram_fifo_ctrl.sv
// sp_ram_fifo_ctrl: stream FIFO over one single-port RAM with a 2-entry output buffer
module sp_ram_fifo_ctrl #(
  parameter int DEPTH = 8192,
  parameter int DATA_WIDTH = 128,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ram_cs,
  output logic                  ram_w_en,
  output logic [AW-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  input  logic                  ram_mem_valid,
  output logic [AW+1:0]         fill_level,
  output logic                  err
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] ram_count;
  logic [DATA_WIDTH-1:0] ob0, ob1;
  logic [1:0] ob_count;
  logic rd_inflight, last_grant;
  logic want_rd, want_wr, gnt_rd, gnt_wr, push, pop, push_hi;
  // Port arbitration: a read is only requested when the output buffer has room reserved for its data
  always_comb begin
    want_rd = rst_n && ram_count != '0 && ({1'b0, ob_count} + {2'b0, rd_inflight}) < 3'd2;
    want_wr = rst_n && in_valid && ram_count != (AW+1)'(DEPTH);
    gnt_rd = want_rd && (!want_wr || !last_grant);
    gnt_wr = want_wr && !gnt_rd;
    push = ram_mem_valid && rd_inflight;
    pop = out_valid && out_ready;
    push_hi = pop ? ob_count == 2'd2 : ob_count == 2'd1;
  end
  assign in_ready = gnt_wr;
  assign ram_cs = gnt_rd || gnt_wr;
  assign ram_w_en = gnt_wr;
  assign ram_addr = gnt_wr ? wr_ptr : rd_ptr;
  assign ram_wr_data = in_data;
  assign out_valid = ob_count != 2'd0;
  assign out_data = ob0;
  assign fill_level = (AW+2)'(ram_count) + (AW+2)'(ob_count) + (AW+2)'(rd_inflight);
  // Pointer, occupancy, output buffer and error state; reset discards in-flight data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ram_count <= '0;
      ob0 <= '0;
      ob1 <= '0;
      ob_count <= '0;
      rd_inflight <= 1'b0;
      last_grant <= 1'b0;
      err <= 1'b0;
    end else begin
      if (gnt_wr) wr_ptr <= wr_ptr == AW'(DEPTH-1) ? '0 : wr_ptr + 1'b1;
      if (gnt_rd) rd_ptr <= rd_ptr == AW'(DEPTH-1) ? '0 : rd_ptr + 1'b1;
      ram_count <= ram_count + (AW+1)'(gnt_wr) - (AW+1)'(gnt_rd);
      rd_inflight <= gnt_rd;
      if (gnt_wr || gnt_rd) last_grant <= gnt_rd;
      if (ram_mem_valid && !rd_inflight) err <= 1'b1;
      if (pop) ob0 <= ob1;
      if (push && !push_hi) ob0 <= ram_rd_data;
      if (push && push_hi) ob1 <= ram_rd_data;
      ob_count <= ob_count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// tb_sp_ram_fifo_ctrl: randomized and directed checks of the FIFO controller against a queue-based model
module tb_sp_ram_fifo_ctrl;
  localparam int D = 5;
  localparam int W = 16;
  localparam int AW = $clog2(D);
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, force_mv = 0, mv_q = 0;
  logic in_ready, out_valid, ram_cs, ram_w_en, ram_mem_valid, err;
  logic [W-1:0] in_data = '0, out_data, ram_wr_data, ram_rd_data = '0;
  logic [AW-1:0] ram_addr;
  logic [AW+1:0] fill_level;
  logic [W-1:0] mem [D];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  sp_ram_fifo_ctrl #(.DEPTH(D), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .ram_cs(ram_cs),
    .ram_w_en(ram_w_en), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
    .ram_mem_valid(ram_mem_valid), .fill_level(fill_level), .err(err)
  );
  // Single-port RAM with 1-cycle read latency and a read strobe; force_mv injects a spurious strobe
  assign ram_mem_valid = mv_q | force_mv;
  always @(posedge clk) begin
    if (ram_cs && ram_w_en && ram_addr < AW'(D)) mem[ram_addr] <= ram_wr_data;
    if (ram_cs && !ram_w_en && ram_addr < AW'(D)) ram_rd_data <= mem[ram_addr];
    mv_q <= ram_cs && !ram_w_en;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Model: q holds every accepted word not yet delivered; ram_cnt = words written but not yet read from RAM
  logic [W-1:0] q [$];
  int ram_cnt = 0, wptr = 0, rptr = 0, pops = 0, ob_exp;
  bit last_g = 0, rd_prev = 0, merr = 0, mon_en = 0, mwr, mrd, ewr, erd;
  always @(negedge clk) if (mon_en) begin
    chk("fill_level", fill_level, q.size());
    if (!rst_n) begin
      chk("in_ready_in_reset", in_ready, 0);
      chk("ram_cs_in_reset", ram_cs, 0);
      q.delete();
      ram_cnt = 0; wptr = 0; rptr = 0; last_g = 0; rd_prev = 0; merr = 0;
    end else begin
      chk("err", err, merr);
      ob_exp = q.size() - ram_cnt - int'(rd_prev);
      chk("out_valid", out_valid, ob_exp != 0);
      if (out_valid && q.size() != 0) chk("out_data", out_data, q[0]);
      mwr = in_valid && ram_cnt != D;
      mrd = ram_cnt != 0 && q.size() - ram_cnt < 2;
      ewr = mwr && (!mrd || last_g);
      erd = mrd && !ewr;
      chk("in_ready", in_ready, ewr);
      chk("ram_cs", ram_cs, ewr || erd);
      if (ram_cs) begin
        chk("ram_w_en", ram_w_en, ewr);
        chk("ram_addr", ram_addr, ram_w_en ? wptr : rptr);
        last_g = !ram_w_en;
      end
      if (ram_cs && ram_w_en) chk("ram_wr_data", ram_wr_data, in_data);
      if (ram_mem_valid && !rd_prev) merr = 1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("pop_from_empty", 1, 0);
        else begin void'(q.pop_front()); pops++; end
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        ram_cnt++;
        wptr = (wptr + 1) % D;
      end
      if (ram_cs && !ram_w_en) begin
        ram_cnt--;
        rptr = (rptr + 1) % D;
      end
      rd_prev = ram_cs && !ram_w_en;
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input string name);
    int k = 0;
    in_valid = 0;
    out_ready = 1;
    while (fill_level != 0 && k < 60) begin step; k++; end
    chk(name, fill_level, 0);
    step;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  int n, p0, accs, k;
  bit acc, prev_w, hit;
  int pin, pout;
  initial begin
    // Reset with a pending producer: nothing may be accepted
    in_valid = 1; in_data = 16'h0007;
    step;
    mon_en = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_err", err, 0);
    step;
    rst_n = 1; in_valid = 0;
    step; step;
    // T1: single word, 3-cycle latency
    in_valid = 1; in_data = 16'h00A5; out_ready = 1;
    @(negedge clk); chk("t1_c0_in_ready", in_ready, 1);
    step; in_valid = 0;
    @(negedge clk); chk("t1_c1_read", {ram_cs, ram_w_en}, 2'b10); chk("t1_c1_fill", fill_level, 1);
    step;
    @(negedge clk); chk("t1_c2_mem_valid", ram_mem_valid, 1); chk("t1_c2_out_valid", out_valid, 0);
    step;
    @(negedge clk); chk("t1_c3_out_valid", out_valid, 1); chk("t1_c3_out_data", out_data, 16'h00A5);
    chk("t1_c3_fill", fill_level, 1);
    step;
    @(negedge clk); chk("t1_c4_fill", fill_level, 0); chk("t1_c4_out_valid", out_valid, 0);
    step;
    // T2: consumer stalled; DEPTH=5 RAM lines plus 2 buffer entries = 7 words
    out_ready = 0; in_valid = 1; in_data = 0; n = 0;
    repeat (20) begin
      @(negedge clk); acc = in_valid && in_ready;
      step;
      if (acc) begin n++; if (n < 8) in_data = W'(n); else in_valid = 0; end
    end
    @(negedge clk);
    chk("t2_accepted", n, 7);
    chk("t2_in_ready", in_ready, 0);
    chk("t2_fill", fill_level, 7);
    step;
    p0 = pops;
    in_valid = 0; out_ready = 1;
    @(negedge clk); chk("t2_head", out_data, 16'h0000);
    drain("t2_drain");
    chk("t2_delivered", pops - p0, 7);
    // T3: random stalls on both sides, producer-heavy then consumer-heavy
    p0 = pops;
    for (int ph = 0; ph < 2; ph++) begin
      pin = ph == 0 ? 3 : 1;
      pout = ph == 0 ? 1 : 3;
      repeat (200) begin
        @(negedge clk); acc = in_valid && in_ready;
        step;
        if (!in_valid || acc) begin
          in_valid = $urandom_range(0, 3) < pin;
          in_data = W'($urandom);
        end
        out_ready = $urandom_range(0, 3) < pout;
      end
    end
    drain("t3_drain");
    chk("t3_progress", pops - p0 >= 40, 1);
    // T4: both sides always active -> RAM busy every cycle, alternating write/read
    in_valid = 1; out_ready = 1; in_data = 16'h1000; accs = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c >= 10) begin
        chk("t4_ram_cs", ram_cs, 1);
        if (c > 10) chk("t4_toggle", ram_w_en, !prev_w);
        if (acc) accs++;
      end
      prev_w = ram_w_en;
      step;
      if (acc) in_data = in_data + 1'b1;
    end
    chk("t4_rate", accs, 10);
    drain("t4_drain");
    // T5: reset while a read is in flight and the buffer holds data
    out_ready = 0; in_valid = 1; in_data = 16'h2000; hit = 0; k = 0;
    while (!hit && k < 30) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      hit = ram_cs && !ram_w_en && out_valid;
      step; k++;
      if (acc) in_data = in_data + 1'b1;
    end
    chk("t5_reached", hit, 1);
    rst_n = 0; in_valid = 0;
    @(negedge clk); chk("t5_inflight", ram_mem_valid, 1);
    step;
    rst_n = 1;
    @(negedge clk);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_fill", fill_level, 0);
    chk("t5_err", err, 0);
    chk("t5_no_mem_valid", ram_mem_valid, 0);
    step;
    in_valid = 1; in_data = 16'hBEEF; out_ready = 1;
    step; in_valid = 0;
    k = 0;
    while (!out_valid && k < 10) begin step; k++; end
    chk("t5_first_out", out_data, 16'hBEEF);
    drain("t5_drain");
    // T6: spurious read strobe sets a sticky error
    step; step;
    force_mv = 1;
    step;
    force_mv = 0;
    @(negedge clk); chk("t6_err_set", err, 1);
    step;
    in_valid = 1; in_data = 16'h3000; out_ready = 1;
    repeat (3) step;
    drain("t6_drain");
    @(negedge clk); chk("t6_err_sticky", err, 1);
    step;
    rst_n = 0;
    step;
    rst_n = 1;
    @(negedge clk); chk("t6_err_cleared", err, 0);
    step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
